// File: rtl/count_seq_ctrl_pkg.sv
// Shared types for the count sequence controller: FSM states, the
// latched command record and the default counter width.
package count_seq_pkg;

    // Default counter datapath width; the latched command record is sized by it.
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Command captured at the handshake and held for the whole sequence.
    typedef struct packed {
        logic [CNT_W-1:0] start;
        logic [CNT_W-1:0] limit;
        logic             dir;
        logic             wrap;
    } cmd_t;

    localparam cmd_t CMD_RESET = '0;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Command handshake bundle between a command source and the controller.
interface count_seq_ctrl_if #(
    parameter int W = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_start;
    logic [W-1:0] cmd_limit;
    logic         cmd_dir;
    logic         cmd_wrap;

    // Command source side.
    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_limit,
        output cmd_dir,
        output cmd_wrap,
        input  cmd_ready
    );

    // Controller side.
    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_limit,
        input  cmd_dir,
        input  cmd_wrap,
        output cmd_ready
    );

endinterface

// File: rtl/count_seq_ctrl_step.sv
// Modulo-2^W increment/decrement of the counter feedback value.
module count_step
    import count_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic [W-1:0] q,
    input  logic         dir,
    output logic [W-1:0] nxt
);

    // Natural wrap of W-bit arithmetic gives the modulo behaviour for free.
    always_comb begin
        nxt = dir ? (q + W'(1)) : (q - W'(1));
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer for an external counter register: loads a start value, steps it
// towards a limit in either direction, optionally reloading at the limit, and
// checks the counter's Q/Q-bar feedback pair for consistency.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    count_seq_ctrl_if.slave       cmd,
    input  logic                  pause,
    input  logic                  abort,
    input  logic [W-1:0]          cnt_q,
    input  logic [W-1:0]          cnt_qbar,
    output logic [W-1:0]          cnt_d,
    output logic                  cnt_we,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap_pulse,
    output logic                  err
);

    state_t       state_q, state_d;
    cmd_t         cmd_q, cmd_d;
    logic         err_q, err_d;
    logic         rdy_q, rdy_d;

    logic [W-1:0] step_val;
    logic         at_limit;
    logic         qbar_bad;

    // The +/-1 arithmetic lives in its own block so it can be reused and
    // checked in isolation.
    count_step #(
        .W (W)
    ) u_step (
        .q   (cnt_q),
        .dir (cmd_q.dir),
        .nxt (step_val)
    );

    // Feedback comparisons used by the RUN and HOLD states.
    always_comb begin
        at_limit = (cnt_q == cmd_q.limit);
        qbar_bad = ((cnt_q ^ cnt_qbar) != {W{1'b1}});
    end

    // Next-state, command latch, sticky error and output decode. Abort beats
    // pause, pause beats the limit compare, and the limit compare beats a
    // plain step.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        err_d         = err_q;
        rdy_d         = 1'b1;
        cnt_d         = '0;
        cnt_we        = 1'b0;
        done          = 1'b0;
        wrap_pulse    = 1'b0;
        cmd.cmd_ready = 1'b0;
        busy          = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                // rdy_q keeps ready low until the first edge after reset
                // release; abort has no meaning here and is ignored.
                cmd.cmd_ready = rdy_q;
                if (rdy_q && cmd.cmd_valid) begin
                    cmd_d.start = cmd.cmd_start;
                    cmd_d.limit = cmd.cmd_limit;
                    cmd_d.dir   = cmd.cmd_dir;
                    cmd_d.wrap  = cmd.cmd_wrap;
                    err_d       = 1'b0;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                cnt_d = cmd_q.start;
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_we  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (qbar_bad) begin
                    err_d = 1'b1;
                end
                cnt_d = at_limit ? cmd_q.start : step_val;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else if (at_limit) begin
                    if (cmd_q.wrap) begin
                        cnt_we     = 1'b1;
                        wrap_pulse = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_we = 1'b1;
                end
            end

            ST_HOLD: begin
                if (qbar_bad) begin
                    err_d = 1'b1;
                end
                cnt_d = cnt_q;
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (!abort) begin
                    done = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched command and flags; reset abandons any sequence at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_RESET;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    assign err = err_q;

endmodule
